// File: rtl/bit_tracker_if.sv
// Signal bundle between the pad-side line, the bit tracker and the UART framer.
// The slave side is the tracker; the master side drives the line and soft clear.
interface bit_tracker_if;
    logic clear_i;
    logic rx_i;
    logic rx_bit_o;
    logic valid_o;
    logic noise_o;
    logic resync_o;
    logic locked_o;

    modport master (
        output clear_i, rx_i,
        input  rx_bit_o, valid_o, noise_o, resync_o, locked_o
    );

    modport slave (
        input  clear_i, rx_i,
        output rx_bit_o, valid_o, noise_o, resync_o, locked_o
    );
endinterface

// File: rtl/bit_tracker.sv
// Oversampled bit recovery: synchronises rx, locks a phase counter to line edges
// and majority-votes a centre window of each bit period.
//
// state | meaning
// HUNT  | waiting for the first line edge, phase counter idle
// TRACK | phase locked; voting, emitting and re-aligning on early/late edges
module bit_tracker #(
    parameter int OVERSAMPLING = 16,
    parameter int VOTE_WINDOW  = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bit_tracker_if.slave bus
);
    localparam int C  = OVERSAMPLING / 2;
    localparam int WS = C - (VOTE_WINDOW - 1) / 2;
    localparam int WE = C + (VOTE_WINDOW - 1) / 2;
    localparam int PW = $clog2(OVERSAMPLING);
    localparam int OW = $clog2(VOTE_WINDOW + 1);

    localparam logic [PW-1:0] P_WS   = PW'(WS);
    localparam logic [PW-1:0] P_WE   = PW'(WE);
    localparam logic [PW-1:0] P_LAST = PW'(OVERSAMPLING - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [OW-1:0] O_HALF = OW'(VOTE_WINDOW / 2);
    localparam logic [OW-1:0] O_FULL = OW'(VOTE_WINDOW);

    typedef enum logic {HUNT, TRACK} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic [PW-1:0]          p;
    logic [OW-1:0]          ones;

    logic          s;
    logic          edge_seen;
    logic          in_win;
    logic [OW-1:0] ones_acc;

    assign s         = sync_q[SYNC_STAGES-1];
    assign edge_seen = s ^ s_d;
    assign in_win    = (p >= P_WS) && (p <= P_WE);
    assign ones_acc  = ones + OW'(in_win & s);

    // Synchroniser resets to the idle level so reset never fakes an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            s_d    <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_i};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= HUNT;
            p            <= '0;
            ones         <= '0;
            bus.rx_bit_o <= 1'b1;
            bus.valid_o  <= 1'b0;
            bus.noise_o  <= 1'b0;
            bus.resync_o <= 1'b0;
            bus.locked_o <= 1'b0;
        end else begin
            bus.valid_o  <= 1'b0;
            bus.resync_o <= 1'b0;
            if (bus.clear_i) begin
                state        <= HUNT;
                p            <= '0;
                ones         <= '0;
                bus.noise_o  <= 1'b0;
                bus.locked_o <= 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        if (edge_seen) begin
                            state        <= TRACK;
                            p            <= P_ONE;
                            ones         <= '0;
                            bus.locked_o <= 1'b1;
                        end
                    end
                    TRACK: begin
                        // Edge seen now is phase 0, so the next cycle is phase 1.
                        if (edge_seen && (p > P_WE)) begin
                            bus.valid_o  <= 1'b1;
                            bus.rx_bit_o <= ones_acc > O_HALF;
                            bus.noise_o  <= (ones_acc != '0) && (ones_acc != O_FULL);
                            p            <= P_ONE;
                            ones         <= '0;
                        end else if (edge_seen && (p != '0) && (p < P_WS)) begin
                            bus.resync_o <= 1'b1;
                            p            <= P_ONE;
                            ones         <= '0;
                        end else if (p == P_LAST) begin
                            bus.valid_o  <= 1'b1;
                            bus.rx_bit_o <= ones_acc > O_HALF;
                            bus.noise_o  <= (ones_acc != '0) && (ones_acc != O_FULL);
                            p            <= '0;
                            ones         <= '0;
                        end else begin
                            p    <= p + P_ONE;
                            ones <= ones_acc;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: doc/bit_tracker.md
# bit_tracker

Parametrised successor to the fixed 16x bit recovery stage for the uart_lite receive path. It synchronises the raw line, locks a phase counter to line edges, and majority-votes a configurable centre window of each bit period. It emits one recovered bit per period with a noise flag, and re-aligns its phase on early or late edges. Sits between the pad input and the UART framing logic.

## Interface
- OVERSAMPLING, 16, clocks per bit period N; integer >= 4.
- VOTE_WINDOW, 3, samples voted per bit W; odd, 1 <= W <= N/2.
- SYNC_STAGES, 2, input synchroniser depth; >= 2.

Ports:
- clk_i  in  1  sample clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- clear_i  in  1  synchronous soft clear; returns the block to HUNT.
- rx_i  in  1  raw asynchronous serial line; idle high.
- rx_bit_o  out  1  recovered bit; qualified by valid_o.
- valid_o  out  1  one-cycle strobe: rx_bit_o and noise_o are new.
- noise_o  out  1  window samples were not unanimous.
- resync_o  out  1  one-cycle strobe: late edge restarted the period without emitting.
- locked_o  out  1  high while in TRACK.

## Operation
- Derived constants: C = N/2, Ws = C-(W-1)/2, We = C+(W-1)/2. Phase counter p has width $clog2(N). Ones counter has width $clog2(W+1).
- Synchroniser: a SYNC_STAGES flop chain with all flops reset to 1. Its output is s, and s_d is s delayed one cycle (reset 1). Edge e = s xor s_d.
- The cycle in which e is seen is phase 0 of a new period, so p loads 1 for the next cycle.
- HUNT: ignore s until e. On e, go to TRACK with p=1 and ones=0.
- TRACK, each cycle, evaluated in priority order:
  - e and p > We (early edge): emit, then p=1, ones=0.
  - e and 0 < p < Ws (late edge): no emit; pulse resync_o; p=1, ones=0.
  - Otherwise (no e, or e with p=0, or e with Ws <= p <= We): normal step.
    - If Ws <= p <= We, ones += s.
    - If p = N-1: emit, then p=0, ones=0. Otherwise p+1.
- Emit: registered result, visible the next cycle.
  - valid_o = 1.
  - rx_bit_o = (ones_final > W/2), where ones_final includes any sample taken in the emitting cycle.
  - noise_o = (ones_final != 0 and ones_final != W).
- Edges inside the window never move the phase; they only affect the vote.
- clear_i has priority over all TRACK rules. Next cycle: HUNT, p=0, ones=0, strobes 0. rx_bit_o holds its value. Synchroniser is unaffected.
- Reset values: state HUNT, p=0, ones=0, rx_bit_o=1, valid_o=0, noise_o=0, resync_o=0, locked_o=0.
- Async reset mid-period: outputs go to reset values immediately, without waiting for a clock. The partial bit is discarded.

## Timing
- Input to s: SYNC_STAGES cycles.
- Clean line, bit boundary aligned to edges: valid_o asserts SYNC_STAGES+N cycles after the first rx_i sample of the bit, then every N cycles.
- Minimum valid_o spacing: We+1 cycles (early-edge case). There is no upper bound while locked.
- valid_o and resync_o never assert in the same cycle. Each pulses for exactly one cycle.
- locked_o rises the cycle after the first detected edge and stays high until clear_i or rst_i.

## Test plan
Defaults throughout: N=16, W=3, SYNC_STAGES=2, so Ws=7, We=9.
- Reset, then rx_i=1 for 200 cycles -> locked_o=0, valid_o never asserts, rx_bit_o=1.
- rx_i=0 for 16 cycles, then 1 for 16 cycles -> locked_o high from cycle 3. valid_o at cycle 18 with rx_bit=0, noise=0. valid_o at cycle 34 with rx_bit=1, noise=0.
- Low bit containing a single high cycle at phase 8 -> valid_o with rx_bit_o=0, noise_o=1. No resync_o, and the next valid_o stays 16 cycles later.
- Bit periods shortened to 12 cycles -> valid_o every 12 cycles with correct bits. No resync_o.
- Edge arriving at phase 3 of a period -> resync_o pulses once, no valid_o for the aborted period. The next valid_o comes 16 cycles after that edge.
- rst_i asserted at phase 10, and separately clear_i at phase 10 -> rst_i: outputs reset with no clock. clear_i: locked_o=0 next cycle and no valid_o until a new edge plus 16 cycles.
